// File: rtl/monostable_driver.sv
// monostable_driver: retriggerable-safe pulse generator for a single output pin.
//
// A trigger in IDLE starts a pulse: io_out is high for On_Cycles enabled cycles, then low for
// at least Off_Cycles enabled cycles. Triggers that arrive while a pulse (or its low gap) is in
// progress are either queued or dropped, depending on build configuration.
//
// Build configuration:
//   MONOSTABLE_DRIVER_PENDING_EN  defined   -> triggers during ON/OFF are queued in a saturating
//                                              counter of depth Max_Pending and replayed after
//                                              each OFF gap.
//                                 undefined -> triggers during ON/OFF are dropped (overflow
//                                              pulses), pending_count is tied to 0.
//
// Parameters:
//   On_Cycles    io_out high time in clk_en-qualified cycles (>= 1)
//   Off_Cycles   minimum low gap after each pulse in clk_en-qualified cycles (>= 1)
//   Max_Pending  depth of the pending-event counter (>= 1)
//
// Ports:
//   clk            clock, rising edge
//   async_rst_n    asynchronous active-low reset
//   clk_en         cycle qualifier; nothing advances while low
//   trigger        active-high event request, sampled when clk_en is high
//   io_out         pin drive, straight from a flop
//   busy           high while not IDLE
//   pending_count  number of queued events
//   overflow       one enabled-cycle pulse when a trigger is dropped

module monostable_driver #(
  parameter int On_Cycles   = 3_500_000,
  parameter int Off_Cycles  = 3_500_000,
  parameter int Max_Pending = 3
) (
  input  logic                             clk,
  input  logic                             async_rst_n,
  input  logic                             clk_en,
  input  logic                             trigger,
  output logic                             io_out,
  output logic                             busy,
  output logic [$clog2(Max_Pending+1)-1:0] pending_count,
  output logic                             overflow
);

  localparam int MaxCycles = (On_Cycles > Off_Cycles) ? On_Cycles : Off_Cycles;
  // Keep at least one bit so degenerate 1-cycle configurations still elaborate.
  localparam int CntW      = (MaxCycles > 1) ? $clog2(MaxCycles) : 1;
  localparam int PendW     = $clog2(Max_Pending + 1);

  localparam logic [CntW-1:0] OnLast  = CntW'(On_Cycles - 1);
  localparam logic [CntW-1:0] OffLast = CntW'(Off_Cycles - 1);

`ifndef SYNTHESIS
  initial begin
    if (On_Cycles < 1 || Off_Cycles < 1 || Max_Pending < 1) begin
      $display("ERROR: monostable_driver illegal parameters On_Cycles=%0d Off_Cycles=%0d Max_Pending=%0d",
               On_Cycles, Off_Cycles, Max_Pending);
      $finish;
    end
  end
`endif

  typedef enum logic [1:0] {StIdle, StOn, StOff} state_e;

  state_e            state_q, state_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              io_out_q, io_out_d;
  logic              busy_q, busy_d;
  logic              ovf_q, ovf_d;
  logic              on_done, off_done;

`ifdef MONOSTABLE_DRIVER_PENDING_EN
  logic [PendW-1:0]  pend_q, pend_d;
  localparam logic [PendW-1:0] PendMax = PendW'(Max_Pending);
`endif

  assign on_done  = (cnt_q == OnLast);
  assign off_done = (cnt_q == OffLast);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    io_out_d = io_out_q;
    busy_d   = busy_q;
    ovf_d    = ovf_q;
`ifdef MONOSTABLE_DRIVER_PENDING_EN
    pend_d   = pend_q;
`endif

    if (clk_en) begin
      ovf_d = 1'b0;
      unique case (state_q)
        StIdle: begin
          // The starting trigger is consumed here, never queued.
          if (trigger) state_d = StOn;
        end
        StOn: begin
          if (on_done) state_d = StOff;
          if (trigger) begin
`ifdef MONOSTABLE_DRIVER_PENDING_EN
            if (pend_q == PendMax) ovf_d = 1'b1;
            else                   pend_d = pend_q + 1'b1;
`else
            ovf_d = 1'b1;
`endif
          end
        end
        StOff: begin
          if (off_done) begin
`ifdef MONOSTABLE_DRIVER_PENDING_EN
            if (pend_q != '0) begin
              // A coincident trigger replaces the event being dequeued.
              state_d = StOn;
              if (!trigger) pend_d = pend_q - 1'b1;
            end else if (trigger) begin
              state_d = StOn;
            end else begin
              state_d = StIdle;
            end
`else
            state_d = StIdle;
            if (trigger) ovf_d = 1'b1;
`endif
          end else if (trigger) begin
`ifdef MONOSTABLE_DRIVER_PENDING_EN
            if (pend_q == PendMax) ovf_d = 1'b1;
            else                   pend_d = pend_q + 1'b1;
`else
            ovf_d = 1'b1;
`endif
          end
        end
        default: state_d = StIdle;
      endcase

      // Counter restarts on every state change and idles at zero.
      if (state_d != state_q || state_q == StIdle) cnt_d = '0;
      else                                         cnt_d = cnt_q + 1'b1;

      io_out_d = (state_d == StOn);
      busy_d   = (state_d != StIdle);
    end
  end

  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      io_out_q <= 1'b0;
      busy_q   <= 1'b0;
      ovf_q    <= 1'b0;
`ifdef MONOSTABLE_DRIVER_PENDING_EN
      pend_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      io_out_q <= io_out_d;
      busy_q   <= busy_d;
      ovf_q    <= ovf_d;
`ifdef MONOSTABLE_DRIVER_PENDING_EN
      pend_q   <= pend_d;
`endif
    end
  end

  assign io_out   = io_out_q;
  assign busy     = busy_q;
  assign overflow = ovf_q;
`ifdef MONOSTABLE_DRIVER_PENDING_EN
  assign pending_count = pend_q;
`else
  assign pending_count = '0;
`endif

endmodule

// File: doc/monostable_driver.md
MONOSTABLE_DRIVER -- requirements
Module: monostable_driver

Interface
REQ-001 SHALL have parameter On_Cycles, default 3_500_000: io_out high time, in clk_en-qualified cycles, legal range 1 or more.
REQ-002 SHALL have parameter Off_Cycles, default 3_500_000: minimum io_out low gap after each pulse, in clk_en-qualified cycles, legal range 1 or more.
REQ-003 SHALL have parameter Max_Pending, default 3: depth of the pending-event counter, legal range 1 or more.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 SHALL have port async_rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port clk_en, input, 1 bit: cycle qualifier; state, counters and outputs advance only when high.
REQ-007 SHALL have port trigger, input, 1 bit: active-high event request, sampled only when clk_en is high.
REQ-008 SHALL have port io_out, output, 1 bit: active-high pin drive, taken directly from a flop with no logic after it.
REQ-009 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.
REQ-010 SHALL have port pending_count, output, $clog2(Max_Pending+1) bits: number of queued events.
REQ-011 SHALL have port overflow, output, 1 bit: one-cycle pulse when a trigger is dropped.

Function
REQ-012 SHALL implement three states: IDLE, ON, OFF.
REQ-013 In IDLE, a trigger SHALL move the FSM to ON, and io_out SHALL go high on the next clk_en edge (latency 1); that trigger is not queued.
REQ-014 ON SHALL last exactly On_Cycles enabled cycles with io_out high, then move to OFF with io_out low.
REQ-015 OFF SHALL last exactly Off_Cycles enabled cycles; at expiry, if pending_count > 0 the FSM SHALL decrement it and enter ON, otherwise it SHALL enter IDLE.
REQ-016 A trigger in ON or OFF SHALL increment pending_count, saturating at Max_Pending.
REQ-017 A trigger arriving when pending_count == Max_Pending SHALL be dropped and SHALL assert overflow for one enabled cycle; pending_count SHALL stay unchanged.
REQ-018 If a trigger coincides with OFF expiry while pending_count > 0, the increment and the decrement SHALL cancel: the count is unchanged and the FSM enters ON.
REQ-019 If a trigger coincides with OFF expiry while pending_count == 0, the FSM SHALL enter ON directly and pending_count SHALL stay 0.
REQ-020 When clk_en is low, every register SHALL hold its value, including the duration counter and the overflow flop.
REQ-021 The duration counter SHALL be $clog2 of max(On_Cycles, Off_Cycles) bits wide, SHALL clear on every state change, and SHALL compare against limit-1.
REQ-022 An illegal parameter value (On_Cycles, Off_Cycles or Max_Pending below 1) SHALL produce a simulation $display error followed by $finish.

Reset
REQ-023 When async_rst_n is low, the block SHALL immediately force state IDLE, io_out 0, busy 0, pending_count 0, overflow 0 and the counter to 0, regardless of clk_en.
REQ-024 A reset asserted mid-ON SHALL drop io_out to 0 at once and discard all queued events.
REQ-025 After reset release, the first trigger seen with clk_en high SHALL start a pulse per REQ-013.

Configuration
REQ-026 SHALL support the macro MONOSTABLE_DRIVER_PENDING_EN; when it is defined, queuing behaves as described in REQ-016 to REQ-018.
REQ-027 When MONOSTABLE_DRIVER_PENDING_EN is undefined:
  - every trigger in ON or OFF SHALL be dropped and SHALL assert overflow;
  - pending_count SHALL be tied to 0;
  - OFF expiry SHALL always return the FSM to IDLE.

Verification
REQ-028 With On=3, Off=2 and clk_en tied high, a single trigger at cycle 0 -> io_out high during cycles 1-3, low from cycle 4, busy falls at cycle 6.
REQ-029 With On=3, Off=2, Max_Pending=2, triggers at cycles 0, 1, 2 and 3 -> pending_count reaches 2, overflow pulses on the 4th trigger, three pulses are emitted each separated by 2 low cycles, and the final pending_count is 0.
REQ-030 Trigger coinciding with OFF expiry with pending_count=1 -> pending_count stays 1 and the next pulse starts without an IDLE cycle.
REQ-031 clk_en high 1 cycle in 4 with On=2 -> io_out high for 8 clk cycles.
REQ-032 async_rst_n asserted in the 2nd ON cycle with pending_count=2 -> io_out is 0 within the same cycle, pending_count is 0, and the FSM is IDLE.
REQ-033 With the macro undefined, a trigger during ON -> overflow pulses once and no second pulse is emitted.
